// File: rtl/pipelined_ripple_adder_pkg.sv
// Shared definitions for the chunked, pipelined ripple-carry add/subtract unit.
// Provides the mode encoding plus width helpers for the design and its bench.
package pipelined_ripple_adder_pkg;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    function automatic int unsigned chunk_width(input int unsigned width, input int unsigned stages);
        return (stages == 0) ? 0 : width / stages;
    endfunction

    function automatic int unsigned clog2_ceil(input int unsigned value);
        int unsigned bits;
        bits = 0;
        while ((64'd1 << bits) < 64'(value)) bits++;
        return bits;
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// Purely combinational ripple-carry adder, one full-adder cell per bit.
module ripple_carry_adder #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    logic [WIDTH:0] carry;

    assign carry[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign c_out = carry[WIDTH];

endmodule

// File: rtl/pipelined_ripple_adder.sv
// Pipelined add/subtract: each stage resolves one CHUNK-bit slice and registers
// the carry, forwarding the unresolved operand bits with valid/ready flow control.
module pipelined_ripple_adder
    import pipelined_ripple_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipelined_ripple_adder: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
    end

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [STAGES:0]  load;

    // Subtraction is a + ~b + 1; a borrow-in cancels that +1.
    assign b_eff   = (mode_e'(sub) == MODE_SUB) ? ~b : b;
    assign cin_eff = c_in ^ sub;

    assign load[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int unsigned LO  = k * CHUNK;
        localparam int unsigned REM = WIDTH - LO - CHUNK;

        logic [CHUNK-1:0]    a_chunk;
        logic [CHUNK-1:0]    b_chunk;
        logic [CHUNK-1:0]    s_chunk;
        logic                carry_in;
        logic                carry_out;
        logic                up_valid;
        logic [LO+CHUNK-1:0] res_d;
        logic [LO+CHUNK-1:0] res_q;
        logic                valid_q;
        logic                carry_q;

        if (k == 0) begin : src
            assign a_chunk  = a[CHUNK-1:0];
            assign b_chunk  = b_eff[CHUNK-1:0];
            assign carry_in = cin_eff;
            assign up_valid = in_valid;
            assign res_d    = s_chunk;
        end else begin : src
            assign a_chunk  = stg[k-1].fwd.a_q[CHUNK-1:0];
            assign b_chunk  = stg[k-1].fwd.b_q[CHUNK-1:0];
            assign carry_in = stg[k-1].carry_q;
            assign up_valid = stg[k-1].valid_q;
            assign res_d    = {s_chunk, stg[k-1].res_q};
        end

        ripple_carry_adder #(
            .WIDTH(CHUNK)
        ) u_rca (
            .a    (a_chunk),
            .b    (b_chunk),
            .c_in (carry_in),
            .sum  (s_chunk),
            .c_out(carry_out)
        );

        // A stage may load when empty or when its content moves on this cycle.
        assign load[k] = !valid_q || load[k+1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                res_q   <= '0;
            end else if (load[k]) begin
                valid_q <= up_valid;
                if (up_valid) begin
                    carry_q <= carry_out;
                    res_q   <= res_d;
                end
            end
        end

        if (k < STAGES - 1) begin : fwd
            logic [REM-1:0] a_d;
            logic [REM-1:0] b_d;
            logic [REM-1:0] a_q;
            logic [REM-1:0] b_q;

            if (k == 0) begin : nxt
                assign a_d = a[WIDTH-1:CHUNK];
                assign b_d = b_eff[WIDTH-1:CHUNK];
            end else begin : nxt
                assign a_d = stg[k-1].fwd.a_q[REM+CHUNK-1:CHUNK];
                assign b_d = stg[k-1].fwd.b_q[REM+CHUNK-1:CHUNK];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (load[k] && up_valid) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end else begin : fin
            logic ovf_q;

            // Carry into the MSB is recovered from the MSB sum bit and its operands.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (load[k] && up_valid) begin
                    ovf_q <= carry_out ^ (a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ s_chunk[CHUNK-1]);
                end
            end
        end
    end

    assign in_ready  = load[0];
    assign out_valid = stg[STAGES-1].valid_q;
    assign sum       = stg[STAGES-1].res_q;
    assign c_out     = stg[STAGES-1].carry_q;
    assign ovf       = stg[STAGES-1].fin.ovf_q;

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Scoreboard bench for pipelined_ripple_adder across several WIDTH/STAGES pairs;
// expectations come from integer arithmetic on the operands.
module tb_pipelined_ripple_adder;
    import pipelined_ripple_adder_pkg::*;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        int          issue;
        bit          strict;
    } exp_t;

    localparam int NCFG = 5;
    localparam int unsigned CFG_W [NCFG] = '{32, 8, 8, 64, 64};
    localparam int unsigned CFG_S [NCFG] = '{4, 1, 8, 4, 16};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int ndone    = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, req, $time);
        end
    endtask

    // Reference: unsigned and signed interpretations evaluated with wide integers.
    function automatic exp_t model(input int unsigned w, input logic [63:0] av, input logic [63:0] bv,
                                   input logic cin, input logic sb);
        exp_t e;
        logic [127:0] ua, ub, u, mask, ucin;
        logic signed [127:0] sa, sbv, r, smax, smin, scin;
        ua   = {64'd0, av};
        ub   = {64'd0, bv};
        ucin = 128'(cin);
        scin = $signed(ucin);
        mask = (128'd1 << w) - 128'd1;
        sa   = $signed(ua);
        sbv  = $signed(ub);
        if (av[w-1]) sa  = sa  - $signed(128'd1 << w);
        if (bv[w-1]) sbv = sbv - $signed(128'd1 << w);
        smax = $signed((128'd1 << (w - 1)) - 128'd1);
        smin = -smax - 128'sd1;
        if (sb) begin
            u      = ua - ub - ucin;
            e.cout = (ua >= ub + ucin);
            r      = sa - sbv - scin;
        end else begin
            u      = ua + ub + ucin;
            e.cout = (u > mask);
            r      = sa + sbv + scin;
        end
        e.sum    = 64'(u & mask);
        e.ovf    = (r > smax) || (r < smin);
        e.issue  = 0;
        e.strict = 1'b0;
        return e;
    endfunction

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int unsigned W = CFG_W[g];
        localparam int unsigned S = CFG_S[g];

        logic         rst_n;
        logic         in_valid;
        logic         in_ready;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c_in;
        logic         sub;
        logic         out_valid;
        logic         out_ready;
        logic [W-1:0] sum;
        logic         c_out;
        logic         ovf;

        pipelined_ripple_adder #(
            .WIDTH (W),
            .STAGES(S)
        ) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .a        (a),
            .b        (b),
            .c_in     (c_in),
            .sub      (sub),
            .out_valid(out_valid),
            .out_ready(out_ready),
            .sum      (sum),
            .c_out    (c_out),
            .ovf      (ovf)
        );

        int   cyc = 0;
        exp_t q[$];

        always @(posedge clk) cyc <= cyc + 1;

        initial begin : monitor
            bit   seen;
            int   first;
            int   lat;
            exp_t e;
            seen  = 1'b0;
            first = 0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    seen = 1'b0;
                end else if (out_valid) begin
                    if (!seen) begin
                        seen  = 1'b1;
                        first = cyc;
                    end
                    if (q.size() == 0) begin
                        chk(1'b0, $sformatf("cfg%0d unexpected_output", g), 64'(sum), 64'd0);
                    end else if (out_ready) begin
                        e   = q.pop_front();
                        lat = first - e.issue;
                        chk(sum == e.sum[W-1:0], $sformatf("cfg%0d sum", g), 64'(sum), e.sum);
                        chk({c_out, ovf} == {e.cout, e.ovf}, $sformatf("cfg%0d cout_ovf", g),
                            64'({c_out, ovf}), 64'({e.cout, e.ovf}));
                        chk(e.strict ? (lat == int'(S)) : (lat >= int'(S)), $sformatf("cfg%0d latency", g),
                            64'(lat), 64'(S));
                        seen = 1'b0;
                    end else begin
                        chk({sum, c_out, ovf} == {q[0].sum[W-1:0], q[0].cout, q[0].ovf},
                            $sformatf("cfg%0d stall_hold", g), 64'(sum), q[0].sum);
                    end
                end
            end
        end

        // Called one time unit after a rising edge; returns one time unit after another.
        task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tc, input logic ts,
                             input exp_t e, output int waited);
            bit got;
            got    = 1'b0;
            waited = 0;
            in_valid = 1'b1;
            a = ta; b = tbv; c_in = tc; sub = ts;
            while (!got && waited <= 200) begin
                @(negedge clk);
                if (in_ready) begin
                    got     = 1'b1;
                    e.issue = cyc;
                    q.push_back(e);
                end else begin
                    waited++;
                end
                @(posedge clk);
                #1;
            end
            if (!got) chk(1'b0, $sformatf("cfg%0d issue_timeout", g), 64'(waited), 64'd0);
            in_valid = 1'b0;
        endtask

        task automatic random_phase(input int n);
            int          sent;
            int          cycles;
            logic [63:0] ra, rb;
            exp_t        e;
            sent   = 0;
            cycles = 0;
            while (sent < n && cycles < n * 20 + 100) begin
                ra        = {$urandom(), $urandom()};
                rb        = {$urandom(), $urandom()};
                in_valid  = ($urandom_range(0, 99) < 75);
                a         = ra[W-1:0];
                b         = rb[W-1:0];
                c_in      = 1'($urandom_range(0, 1));
                sub       = 1'($urandom_range(0, 1));
                out_ready = ($urandom_range(0, 99) < 60);
                @(negedge clk);
                if (in_valid && in_ready) begin
                    e       = model(W, 64'(a), 64'(b), c_in, sub);
                    e.issue = cyc;
                    q.push_back(e);
                    sent++;
                end
                cycles++;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0;
            chk(sent == n, $sformatf("cfg%0d random_sent", g), 64'(sent), 64'(n));
        endtask

        task automatic drain();
            in_valid  = 1'b0;
            out_ready = 1'b1;
            for (int i = 0; i < int'(S) + 300 && q.size() != 0; i++) @(negedge clk);
            @(posedge clk);
            #1;
            chk(q.size() == 0, $sformatf("cfg%0d drain", g), 64'(q.size()), 64'd0);
        endtask

        task automatic stream_random(input int n);
            logic [63:0] ra, rb;
            logic        rc, rs;
            exp_t        e;
            int          w;
            out_ready = 1'b1;
            for (int i = 0; i < n; i++) begin
                ra = {$urandom(), $urandom()};
                rb = {$urandom(), $urandom()};
                rc = 1'($urandom_range(0, 1));
                rs = 1'($urandom_range(0, 1));
                e  = model(W, 64'(ra[W-1:0]), 64'(rb[W-1:0]), rc, rs);
                e.strict = 1'b1;
                issue(ra[W-1:0], rb[W-1:0], rc, rs, e, w);
                chk(w == 0, $sformatf("cfg%0d stream_in_ready", g), 64'(w), 64'd0);
            end
        endtask

        task automatic reset_and_release();
            rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b0;
            repeat (2) @(negedge clk);
            chk(out_valid == 1'b0 && sum == '0 && c_out == 1'b0 && ovf == 1'b0,
                $sformatf("cfg%0d reset_state", g), 64'(sum), 64'd0);
            chk(in_ready == 1'b1, $sformatf("cfg%0d reset_in_ready", g), 64'(in_ready), 64'd1);
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            @(posedge clk);
            #1;
        endtask

        if (g == 0) begin : directed
            function automatic exp_t mk(input logic [63:0] s, input logic co, input logic ov);
                exp_t e;
                e.sum = s; e.cout = co; e.ovf = ov; e.issue = 0; e.strict = 1'b1;
                return e;
            endfunction

            initial begin
                int          w;
                int          acc;
                int          stale;
                logic [63:0] ra, rb;
                exp_t        e;

                reset_and_release();
                out_ready = 1'b1;
                issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, MODE_ADD, mk(64'h0000_0000, 1'b1, 1'b0), w);
                issue(32'h0000_0005, 32'h0000_0007, 1'b0, MODE_SUB, mk(64'hFFFF_FFFE, 1'b0, 1'b0), w);
                issue(32'h8000_0000, 32'h0000_0001, 1'b0, MODE_SUB, mk(64'h7FFF_FFFF, 1'b1, 1'b1), w);
                issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, MODE_ADD, mk(64'h8000_0000, 1'b0, 1'b1), w);
                drain();

                stream_random(16);
                drain();

                out_ready = 1'b0;
                in_valid  = 1'b1;
                acc       = 0;
                for (int i = 0; i < 8; i++) begin
                    ra = {$urandom(), $urandom()};
                    rb = {$urandom(), $urandom()};
                    a = ra[W-1:0]; b = rb[W-1:0];
                    c_in = 1'($urandom_range(0, 1));
                    sub  = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    if (in_ready) begin
                        e       = model(W, 64'(a), 64'(b), c_in, sub);
                        e.issue = cyc;
                        q.push_back(e);
                        acc++;
                    end
                    @(posedge clk);
                    #1;
                end
                in_valid = 1'b0;
                chk(acc == int'(S), "cfg0 bp_accepts", 64'(acc), 64'(S));
                repeat (5) @(posedge clk);
                #1;
                random_phase(12);
                drain();

                out_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    e = model(W, 64'(i + 1), 64'(i * 3), 1'b0, 1'b0);
                    issue(W'(i + 1), W'(i * 3), 1'b0, MODE_ADD, e, w);
                end
                repeat (2) @(posedge clk);
                #3;
                rst_n = 1'b0;
                #1;
                chk(out_valid == 1'b0 && sum == '0, "cfg0 reset_async_clear", 64'(sum), 64'd0);
                q.delete();
                @(negedge clk);
                #1;
                rst_n = 1'b1;
                @(negedge clk);
                chk(in_ready == 1'b1, "cfg0 reset_release_ready", 64'(in_ready), 64'd1);
                out_ready = 1'b1;
                stale = 0;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    if (out_valid) stale++;
                end
                chk(stale == 0, "cfg0 no_stale", 64'(stale), 64'd0);
                @(posedge clk);
                #1;
                stream_random(2);
                drain();

                random_phase(40);
                drain();
                ndone++;
            end
        end else begin : sweep
            initial begin
                reset_and_release();
                stream_random(8);
                drain();
                random_phase(60);
                drain();
                ndone++;
            end
        end
    end

    initial begin
        for (int i = 0; i < 60000 && ndone < NCFG; i++) @(posedge clk);
        if (ndone < NCFG) chk(1'b0, "global_timeout", 64'(ndone), 64'(NCFG));
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
